// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [NUM_COLS-1:0] COL_FIRST = 3'b100;

  localparam logic [3:0] KEY_0 = 4'd0;
  localparam logic [3:0] KEY_1 = 4'd1;
  localparam logic [3:0] KEY_2 = 4'd2;
  localparam logic [3:0] KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4;
  localparam logic [3:0] KEY_5 = 4'd5;
  localparam logic [3:0] KEY_6 = 4'd6;
  localparam logic [3:0] KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8;
  localparam logic [3:0] KEY_9 = 4'd9;

  // Column 1 -> 2 -> 3 -> 1 (strobe bit moves toward the LSB).
  function automatic logic [NUM_COLS-1:0] rotate_col(input logic [NUM_COLS-1:0] c);
    return {c[0], c[NUM_COLS-1:1]};
  endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// Maps a {rows, cols} strobe/sense pair to a key digit; anything not one-hot/one-hot on a real key is illegal.
module keypad_key_decode
  import keypad_pkg::*;
(
  input  logic [NUM_ROWS+NUM_COLS-1:0] code,
  output logic [3:0]                   digit,
  output logic                         legal
);

  always_comb begin
    digit = KEY_0;
    legal = 1'b1;
    case (code)
      7'b1000_100: digit = KEY_1;
      7'b1000_010: digit = KEY_2;
      7'b1000_001: digit = KEY_3;
      7'b0100_100: digit = KEY_4;
      7'b0100_010: digit = KEY_5;
      7'b0100_001: digit = KEY_6;
      7'b0010_100: digit = KEY_7;
      7'b0010_010: digit = KEY_8;
      7'b0010_001: digit = KEY_9;
      7'b0001_010: digit = KEY_0;
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing 4x3 keypad scanner with press/release debouncing and one pulse per accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                key_held
);

  localparam int DW  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int DBW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;

  logic [NUM_ROWS-1:0]          sync1, rows_s;
  state_t                       state, state_nx;
  logic [NUM_COLS-1:0]          col, col_nx;
  logic [DW-1:0]                dwell, dwell_nx;
  logic [DBW-1:0]               cnt, cnt_nx;
  logic [NUM_ROWS+NUM_COLS-1:0] cand, cand_nx;
  logic [3:0]                   digit_nx, key_digit;
  logic                         valid_nx, held_nx, key_legal, sample, last_match;

  keypad_key_decode u_decode (
    .code  ({rows_s, col}),
    .digit (key_digit),
    .legal (key_legal)
  );

  assign col_out    = col;
  assign sample     = (dwell == DW'(SCAN_DIV - 1));
  assign last_match = (cnt == DBW'(DEBOUNCE_N - 1));

  always_comb begin
    state_nx = state;
    col_nx   = col;
    dwell_nx = sample ? '0 : dwell + DW'(1);
    cnt_nx   = cnt;
    cand_nx  = cand;
    digit_nx = digit;
    valid_nx = 1'b0;
    held_nx  = key_held;
    // All decisions happen on the last dwell cycle, so the dwell counter
    // is already wrapping to 0 whenever the state changes.
    if (sample) begin
      case (state)
        SCAN: begin
          if (key_legal) begin
            state_nx = DEBOUNCE;
            cand_nx  = {rows_s, col};
            cnt_nx   = '0;
          end else begin
            col_nx = rotate_col(col);
          end
        end
        DEBOUNCE: begin
          if ({rows_s, col} == cand) begin
            if (last_match) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
              digit_nx = key_digit;
              valid_nx = 1'b1;
              held_nx  = 1'b1;
            end else begin
              cnt_nx = cnt + DBW'(1);
            end
          end else begin
            state_nx = SCAN;
            col_nx   = rotate_col(col);
            cnt_nx   = '0;
          end
        end
        PRESSED: begin
          if (rows_s == '0) begin
            state_nx = RELEASE;
            cnt_nx   = '0;
          end
        end
        RELEASE: begin
          if (rows_s != '0) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (last_match) begin
            state_nx = SCAN;
            col_nx   = rotate_col(col);
            cnt_nx   = '0;
            held_nx  = 1'b0;
          end else begin
            cnt_nx = cnt + DBW'(1);
          end
        end
        default: begin
          state_nx = SCAN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      rows_s      <= '0;
      state       <= SCAN;
      col         <= COL_FIRST;
      dwell       <= '0;
      cnt         <= '0;
      cand        <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      sync1       <= row_in;
      rows_s      <= sync1;
      state       <= state_nx;
      col         <= col_nx;
      dwell       <= dwell_nx;
      cnt         <= cnt_nx;
      cand        <= cand_nx;
      digit       <= digit_nx;
      digit_valid <= valid_nx;
      key_held    <= held_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed keypad scenarios with a pulse scoreboard drained by a forked monitor.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic [3:0] digit;
  logic       digit_valid;
  logic       key_held;

  // keys[(row-1)*3 + (col-1)] models a closed switch in the matrix.
  logic [11:0] keys;
  int          errors = 0;
  int          checks = 0;
  int          exp_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_in      (row_in),
    .col_out     (col_out),
    .digit       (digit),
    .digit_valid (digit_valid),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && col_out[2-c]) row_in[3-r] = 1'b1;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic release_all(input string nm);
    int n = 0;
    keys = '0;
    while (key_held && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(nm, key_held, 0);
    cyc(10);
  endtask

  task automatic col_sweep(input string nm, input int n);
    logic [2:0] mask = '0;
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      mask |= col_out;
      if (!$onehot(col_out)) bad++;
    end
    check({nm, "_cols_visited"}, mask, 7);
    check({nm, "_onehot"}, bad, 0);
    check({nm, "_not_held"}, key_held, 0);
  endtask

  task automatic wait_col(input logic [2:0] c);
    int n = 0;
    while (col_out != c && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_col", col_out, c);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_col"}, col_out, 3'b100);
    check({nm, "_digit"}, digit, 0);
    check({nm, "_valid"}, digit_valid, 0);
    check({nm, "_held"}, key_held, 0);
  endtask

  initial begin
    int n;
    keys  = '0;
    rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && digit_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got digit %0d, expected no pulse", digit);
          end else begin
            check("pulse_digit", digit, exp_q.pop_front());
            check("held_at_pulse", key_held, 1);
          end
        end
      end
    join_none

    cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(2);

    // Key 2, then measure release latency.
    exp_q.push_back(2);
    keys[1] = 1'b1;
    wait_drain("key2_pulse");
    cyc(30);
    check("key2_held_while_pressed", key_held, 1);
    check("key2_col_frozen", col_out, 3'b010);
    keys = '0;
    n = 0;
    while (key_held && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("key2_release_latency_ok", int'(n >= 14 && n <= 19), 1);
    cyc(10);

    // Key 0 (row 4 / column 2).
    exp_q.push_back(0);
    keys[10] = 1'b1;
    wait_drain("key0_pulse");
    release_all("key0_release");

    // Illegal row 4 / column 1 and row 4 / column 3.
    keys[9] = 1'b1;
    col_sweep("illegal_r4c1", 60);
    keys = '0;
    keys[11] = 1'b1;
    col_sweep("illegal_r4c3", 60);
    keys = '0;
    cyc(10);

    // Two rows on column 1 -> rows 4'b1100.
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    col_sweep("multirow", 60);
    keys = '0;
    cyc(10);

    // Bouncing key 5 settles to one press.
    exp_q.push_back(5);
    for (int i = 0; i < 14; i++) begin
      keys[4] = ~keys[4];
      cyc(3);
    end
    keys[4] = 1'b1;
    wait_drain("bounce_key5_pulse");
    release_all("bounce_release");

    // 9 held, 7 added, 9 released, 7 released: only 9 reports.
    exp_q.push_back(9);
    keys[8] = 1'b1;
    wait_drain("key9_pulse");
    keys[6] = 1'b1;
    cyc(30);
    keys[8] = 1'b0;
    cyc(2);
    release_all("rollover_release");
    cyc(30);
    exp_q.push_back(7);
    keys[6] = 1'b1;
    wait_drain("key7_fresh_pulse");
    release_all("key7_release");

    // Reset during debounce of key 3; the key is re-detected afterwards.
    wait_col(3'b100);
    keys[2] = 1'b1;
    wait_col(3'b001);
    cyc(8);
    check("key3_in_debounce_no_held", key_held, 0);
    rst_n = 1'b0;
    cyc(2);
    check_reset_outputs("midpress_reset");
    exp_q.push_back(3);
    rst_n = 1'b1;
    wait_drain("key3_after_reset_pulse");
    release_all("key3_release");

    cyc(20);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
